vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_axis_counter.sv | 27 ++
 rtl/vga_timing_gen.sv | 97 +++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 640x480@60 porch/sync widths,
// derived totals and the coordinate width used by the timing generator.
package vga_timing_pkg;

  localparam int unsigned COORD_W       = 10;
  localparam int unsigned COORD_MAX_TOT = 1 << COORD_W;

  localparam int unsigned DEF_H_VIS  = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;

  localparam int unsigned DEF_V_VIS  = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 33;

  localparam int unsigned H_TOT = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOT = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Single-axis position counter: counts 0..TOTAL-1 on inc, flags the wrap
// combinationally so the next axis can advance on the same edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL = H_TOT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output coord_t       count,
  output logic         wrap
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters plus a registered output stage
// presenting position, syncs, visibility and line/frame pulses for one pixel.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS  = DEF_H_VIS,
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned H_SYNC = DEF_H_SYNC,
  parameter int unsigned H_BP   = DEF_H_BP,
  parameter int unsigned V_VIS  = DEF_V_VIS,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  output logic               h_sync,
  output logic               v_sync,
  output logic               onscreen,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic [7:0]         frame_count
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > COORD_MAX_TOT || V_TOTAL > COORD_MAX_TOT) begin : g_tot_check
    $error("vga_timing_gen: horizontal or vertical total exceeds 1024");
  end

  localparam coord_t HS_LO  = coord_t'(H_VIS + H_FP);
  localparam coord_t HS_HI  = coord_t'(H_VIS + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO  = coord_t'(V_VIS + V_FP);
  localparam coord_t VS_HI  = coord_t'(V_VIS + V_FP + V_SYNC - 1);
  localparam coord_t H_LIM  = coord_t'(H_VIS);
  localparam coord_t V_LIM  = coord_t'(V_VIS);

  coord_t h_cnt, v_cnt;
  logic   h_wrap, v_wrap;
  logic   at_origin;
  logic   frame_done;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ce),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);

  // frame_done marks that a full frame has been traversed, so the
  // frame_start right after reset does not bump frame_count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      onscreen    <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      frame_done  <= 1'b0;
    end else if (ce) begin
      x           <= h_cnt;
      y           <= v_cnt;
      h_sync      <= !in_span(h_cnt, HS_LO, HS_HI);
      v_sync      <= !in_span(v_cnt, VS_LO, VS_HI);
      onscreen    <= (h_cnt < H_LIM) && (v_cnt < V_LIM);
      line_start  <= (h_cnt == '0);
      frame_start <= at_origin;
      if (at_origin) begin
        frame_done <= 1'b0;
        if (frame_done) begin
          frame_count <= frame_count + 8'd1;
        end
      end else if (v_wrap) begin
        frame_done <= 1'b1;
      end
    end
  end

endmodule
